// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared types and constants for the LED PWM controller
package led_pwm_pkg;

    localparam int MODE_W    = 2;
    localparam int BLINK_BIT = 7;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer, press pulse and long-press reset latch
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES   = 48000,
    parameter int LONG_PRESS_CYCLES = 96000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic usr_btn,
    output logic btn_level,
    output logic btn_press,
    output logic rst_n
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic            level_q, level_d, press_q, press_d, latch_q, latch_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            sample;

    // Debounce toggles the level only after DEBOUNCE_CYCLES differing samples in a row;
    // the long-press counter saturates so the latch can never be missed or re-armed.
    always_comb begin
        sync1_d  = usr_btn;
        sync2_d  = sync1_q;
        sample   = sync2_q ^ BTN_ACTIVE_LOW;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        lp_cnt_d = lp_cnt_q;
        if (sample == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d = '0;
            level_d  = ~level_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d = level_d & ~level_q;
        if (!level_q) begin
            lp_cnt_d = '0;
        end else if (lp_cnt_q != LP_LAST) begin
            lp_cnt_d = lp_cnt_q + 1'b1;
        end
        latch_d = latch_q | (level_q & (lp_cnt_q == LP_LAST));
    end

    // State registers; synchroniser resets to the released pin level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= BTN_ACTIVE_LOW;
            sync2_q  <= BTN_ACTIVE_LOW;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            latch_q  <= 1'b0;
            db_cnt_q <= '0;
            lp_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            press_q  <= press_d;
            latch_q  <= latch_d;
            db_cnt_q <= db_cnt_d;
            lp_cnt_q <= lp_cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign rst_n     = ~latch_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED PWM controller with button and reset-request handling
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS          = 3,
    parameter int PWM_WIDTH         = 8,
    parameter int PRESCALE          = 188,
    parameter int DEBOUNCE_CYCLES   = 48000,
    parameter int LONG_PRESS_CYCLES = 96000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1,
    parameter bit LED_ACTIVE_LOW    = 1'b0,
    localparam int CHAN_W = $clog2((CHANNELS > 2) ? CHANNELS : 2)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [PWM_WIDTH-1:0] cfg_duty,
    input  logic [MODE_W-1:0]    cfg_mode,
    output logic                 cfg_err,
    output logic [CHANNELS-1:0]  led_out,
    input  logic                 usr_btn,
    output logic                 btn_level,
    output logic                 btn_press,
    output logic                 rst_n
);

    localparam int PRE_W = $clog2(PRESCALE + 1);
    localparam int CHK_W = CHAN_W + 1;
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

    logic                 ready_q, ready_d, err_q, err_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
    logic [7:0]           frame_q, frame_d;
    logic                 accept, chan_ok, step, period_end;
    logic [CHANNELS-1:0]  led_raw;

    // Handshake plus the shared timebase: prescaler, PWM counter and frame counter.
    always_comb begin
        accept     = cfg_valid & ready_q;
        chan_ok    = ({1'b0, cfg_chan} < CHK_W'(CHANNELS));
        ready_d    = ~accept;
        err_d      = accept & ~chan_ok;
        step       = (pre_q == PRE_LAST);
        pre_d      = step ? '0 : pre_q + 1'b1;
        pwm_d      = step ? pwm_q + 1'b1 : pwm_q;
        period_end = step & (pwm_q == DUTY_MAX);
        frame_d    = period_end ? frame_q + 8'd1 : frame_q;
    end

    // Shared registers; cfg_ready comes up on the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pre_q   <= '0;
            pwm_q   <= '0;
            frame_q <= '0;
        end else begin
            ready_q <= ready_d;
            err_q   <= err_d;
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            frame_q <= frame_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [PWM_WIDTH-1:0] duty_q, duty_d, ramp_q, ramp_d, shadow_q, shadow_d, eff_duty;
        led_mode_t            mode_q, mode_d;
        logic                 rising_q, rising_d, led_q, led_d, wr_en;

        assign wr_en = accept & chan_ok & (cfg_chan == CHAN_W'(c));

        // Effective duty per mode, triangle ramp, shadow capture at period end and compare.
        always_comb begin
            duty_d   = duty_q;
            mode_d   = mode_q;
            ramp_d   = ramp_q;
            rising_d = rising_q;
            shadow_d = shadow_q;
            eff_duty = '0;
            case (mode_q)
                MODE_STATIC:  eff_duty = duty_q;
                MODE_BLINK:   eff_duty = frame_q[BLINK_BIT] ? duty_q : '0;
                MODE_BREATHE: eff_duty = ramp_q;
                default:      eff_duty = '0;
            endcase
            if (period_end) begin
                shadow_d = eff_duty;
                if (duty_q == '0) begin
                    ramp_d   = '0;
                    rising_d = 1'b1;
                end else if (rising_q) begin
                    if (ramp_q >= duty_q) begin
                        rising_d = 1'b0;
                        ramp_d   = ramp_q - 1'b1;
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end else if (ramp_q == '0) begin
                    rising_d = 1'b1;
                    ramp_d   = PWM_WIDTH'(1);
                end else begin
                    ramp_d = ramp_q - 1'b1;
                end
            end
            if (wr_en) begin
                duty_d   = cfg_duty;
                mode_d   = led_mode_t'(cfg_mode);
                ramp_d   = '0;
                rising_d = 1'b1;
            end
            led_d = (shadow_q == DUTY_MAX) | (pwm_q < shadow_q);
        end

        // Per-channel registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                duty_q   <= '0;
                mode_q   <= MODE_OFF;
                ramp_q   <= '0;
                rising_q <= 1'b1;
                shadow_q <= '0;
                led_q    <= 1'b0;
            end else begin
                duty_q   <= duty_d;
                mode_q   <= mode_d;
                ramp_q   <= ramp_d;
                rising_q <= rising_d;
                shadow_q <= shadow_d;
                led_q    <= led_d;
            end
        end

        assign led_raw[c] = led_q;
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
        .BTN_ACTIVE_LOW   (BTN_ACTIVE_LOW)
    ) u_btn (
        .clock    (clock),
        .reset_n  (reset_n),
        .usr_btn  (usr_btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .rst_n    (rst_n)
    );

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign led_out   = led_raw ^ {CHANNELS{LED_ACTIVE_LOW}};

endmodule
